emmc_host_traffic_gen: RTL and testbench

//  Parametrised host-side traffic generator for eMMC state-machine benches. Issues bursts of

---
 rtl/emmc_tg_pkg.sv | 47 ++++
 rtl/emmc_tg_pattern.sv | 47 ++++
 rtl/emmc_host_traffic_gen.sv | 158 +++++++++++++++
 tb/tb_emmc_host_traffic_gen.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/emmc_tg_pkg.sv
// Shared types and helpers for the eMMC host traffic generator.
// Optional read-data checking is enabled by defining EMMC_TG_CHECK_EN.
package emmc_tg_pkg;

    typedef enum logic [1:0] {
        TG_ALT  = 2'd0,
        TG_INC  = 2'd1,
        TG_LFSR = 2'd2
    } tg_mode_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } tg_state_e;

    // Alternating pattern start value, 'h55 replicated; truncate to the data width.
    localparam logic [63:0] ALT_BASE = {8{8'h55}};

    // Right-shifting Galois LFSR tap masks (maximal-length polynomials) by width.
    function automatic logic [63:0] lfsr_taps(input int unsigned w);
        case (w)
            4:       return 64'hC;
            5:       return 64'h14;
            6:       return 64'h30;
            7:       return 64'h60;
            8:       return 64'hB8;
            9:       return 64'h110;
            10:      return 64'h240;
            12:      return 64'hE08;
            16:      return 64'hB400;
            32:      return 64'h8020_0003;
            default: return (64'd1 << (w - 1)) | 64'd1;
        endcase
    endfunction

    // Reserved encoding 3 falls back to the alternating pattern.
    function automatic tg_mode_e map_mode(input logic [1:0] m);
        case (m)
            2'd1:    return TG_INC;
            2'd2:    return TG_LFSR;
            default: return TG_ALT;
        endcase
    endfunction

endpackage

// File: rtl/emmc_tg_pattern.sv
// Data pattern generator: loads the start value of a mode and advances one word per request.
module emmc_tg_pattern
    import emmc_tg_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned LFSR_SEED = 'h5A
) (
    input  logic          clk_i,
    input  logic          arst_i,
    input  logic          load_i,
    input  logic          adv_i,
    input  tg_mode_e      mode_i,
    output logic [DW-1:0] dat_o
);

    localparam logic [DW-1:0] ALT_START  = DW'(ALT_BASE);
    localparam logic [DW-1:0] LFSR_START = DW'(LFSR_SEED);
    localparam logic [DW-1:0] TAPS       = DW'(lfsr_taps(DW));

    function automatic logic [DW-1:0] start_of(input tg_mode_e m);
        case (m)
            TG_INC:  return '0;
            TG_LFSR: return LFSR_START;
            default: return ALT_START;
        endcase
    endfunction

    function automatic logic [DW-1:0] next_of(input tg_mode_e m, input logic [DW-1:0] v);
        case (m)
            TG_INC:  return v + DW'(1);
            TG_LFSR: return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
            default: return ~v;
        endcase
    endfunction

    // Pattern register: load has priority over advance.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            dat_o <= ALT_START;
        end else if (load_i) begin
            dat_o <= start_of(mode_i);
        end else if (adv_i) begin
            dat_o <= next_of(mode_i, dat_o);
        end
    end

endmodule

// File: rtl/emmc_host_traffic_gen.sv
// Host-side traffic generator: write burst then read burst of equal length, per round.
// Define EMMC_TG_CHECK_EN to compare read data against the regenerated pattern.
module emmc_host_traffic_gen
    import emmc_tg_pkg::*;
#(
    parameter int unsigned DW        = 8,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned ROUNDS    = 1,
    parameter int unsigned LFSR_SEED = 'h5A,
    parameter int unsigned ERR_W     = 16
) (
    input  logic             clk_i,
    input  logic             arst_i,
    input  logic             enable_i,
    input  logic [1:0]       mode_i,
    input  logic             host_ready_i,
    input  logic [DW-1:0]    host_rd_dat_i,
    output logic             host_start_o,
    output logic             host_we_o,
    output logic [DW-1:0]    host_wr_dat_o,
    output logic             busy_o,
    output logic             done_o,
    output logic [ERR_W-1:0] err_cnt_o
);

    localparam int unsigned WORD_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(BURST_LEN - 1);
    localparam logic [31:0] ROUND_LIMIT = 32'(ROUNDS);

    tg_state_e         state;
    tg_mode_e          mode_q;
    logic [WORD_W-1:0] word;
    logic [31:0]       round;

    logic     accept_c;
    logic     run_c;
    logic     wr_acc_c;
    logic     rd_acc_c;
    logic     last_c;
    logic     finish_c;
    tg_mode_e mode_sel_c;

    // Handshake decode; the pattern mode comes straight from mode_i only while loading.
    always_comb begin
        accept_c   = host_start_o && host_ready_i;
        run_c      = (state == IDLE) && enable_i;
        wr_acc_c   = (state == WR) && accept_c;
        rd_acc_c   = (state == RD) && accept_c;
        last_c     = (word == LAST_WORD);
        finish_c   = !enable_i || ((ROUND_LIMIT != 32'd0) && (round + 32'd1 == ROUND_LIMIT));
        mode_sel_c = (state == IDLE) ? map_mode(mode_i) : mode_q;
    end

    // Write data generator; not reloaded between rounds so each round carries fresh data.
    emmc_tg_pattern #(.DW(DW), .LFSR_SEED(LFSR_SEED)) u_wr_gen (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .load_i (run_c),
        .adv_i  (wr_acc_c),
        .mode_i (mode_sel_c),
        .dat_o  (host_wr_dat_o)
    );

    // Sequencer FSM with registered handshake and status outputs.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state        <= IDLE;
            mode_q       <= TG_ALT;
            word         <= '0;
            round        <= '0;
            host_start_o <= 1'b0;
            host_we_o    <= 1'b1;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable_i) begin
                        state        <= WR;
                        mode_q       <= map_mode(mode_i);
                        word         <= '0;
                        round        <= '0;
                        host_start_o <= 1'b1;
                        host_we_o    <= 1'b1;
                        busy_o       <= 1'b1;
                    end
                end
                WR: begin
                    if (accept_c) begin
                        if (last_c) begin
                            state     <= RD;
                            word      <= '0;
                            host_we_o <= 1'b0;
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                RD: begin
                    if (accept_c) begin
                        if (last_c) begin
                            word      <= '0;
                            round     <= round + 32'd1;
                            host_we_o <= 1'b1;
                            if (finish_c) begin
                                state        <= DONE;
                                host_start_o <= 1'b0;
                                busy_o       <= 1'b0;
                                done_o       <= 1'b1;
                            end else begin
                                state <= WR;
                            end
                        end else begin
                            word <= word + WORD_W'(1);
                        end
                    end
                end
                DONE: begin
                    if (!enable_i) begin
                        state  <= IDLE;
                        done_o <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef EMMC_TG_CHECK_EN
    logic [DW-1:0] chk_dat;

    // Check generator tracks the write generator and lags it by one burst.
    emmc_tg_pattern #(.DW(DW), .LFSR_SEED(LFSR_SEED)) u_chk_gen (
        .clk_i  (clk_i),
        .arst_i (arst_i),
        .load_i (run_c),
        .adv_i  (rd_acc_c),
        .mode_i (mode_sel_c),
        .dat_o  (chk_dat)
    );

    // Saturating mismatch counter, cleared when a new run starts.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            err_cnt_o <= '0;
        end else if (run_c) begin
            err_cnt_o <= '0;
        end else if (rd_acc_c && (host_rd_dat_i != chk_dat) && (err_cnt_o != '1)) begin
            err_cnt_o <= err_cnt_o + ERR_W'(1);
        end
    end
`else
    logic unused_rd_dat;
    assign unused_rd_dat = ^host_rd_dat_i;
    assign err_cnt_o     = '0;
`endif

endmodule

// File: tb/tb_emmc_host_traffic_gen.sv
// Randomized bench for emmc_host_traffic_gen: two instances (DW=8/BURST=4/ROUNDS=2 and
// DW=4/BURST=4/ROUNDS=0) checked against a transaction-level pattern model.
module tb_emmc_host_traffic_gen;
    import emmc_tg_pkg::*;

    localparam int unsigned SEED = 'h5A;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [1:0]       en  = '0;
    logic [1:0][1:0]  mode = '0;
    logic [1:0]       rdy = '0;
    logic [1:0][7:0]  rd_dat = '0;
    logic [1:0]       start, we, busy, done;
    logic [1:0][7:0]  wr_dat;
    logic [1:0][15:0] err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    emmc_host_traffic_gen #(.DW(8), .BURST_LEN(4), .ROUNDS(2), .LFSR_SEED(SEED), .ERR_W(16)) u_dut_a (
        .clk_i(clk), .arst_i(rst), .enable_i(en[0]), .mode_i(mode[0]),
        .host_ready_i(rdy[0]), .host_rd_dat_i(rd_dat[0]),
        .host_start_o(start[0]), .host_we_o(we[0]), .host_wr_dat_o(wr_dat[0]),
        .busy_o(busy[0]), .done_o(done[0]), .err_cnt_o(err[0])
    );

    emmc_host_traffic_gen #(.DW(4), .BURST_LEN(4), .ROUNDS(0), .LFSR_SEED(SEED), .ERR_W(16)) u_dut_b (
        .clk_i(clk), .arst_i(rst), .enable_i(en[1]), .mode_i(mode[1]),
        .host_ready_i(rdy[1]), .host_rd_dat_i(rd_dat[1][3:0]),
        .host_start_o(start[1]), .host_we_o(we[1]), .host_wr_dat_o(wr_dat[1][3:0]),
        .busy_o(busy[1]), .done_o(done[1]), .err_cnt_o(err[1])
    );
    assign wr_dat[1][7:4] = 4'h0;

    function automatic int dw_of(input int i);
        return (i == 0) ? 8 : 4;
    endfunction

    function automatic int rounds_of(input int i);
        return (i == 0) ? 2 : 0;
    endfunction

    localparam int BL = 4;

    // Value of word idx of a run's data stream, computed from the pattern definitions.
    function automatic logic [7:0] pat(input int dw, input logic [1:0] m, input int idx);
        logic [7:0] msk;
        logic [7:0] taps;
        logic [7:0] v;
        msk  = 8'((32'd1 << dw) - 32'd1);
        taps = 8'(lfsr_taps(dw));
        case (m)
            2'd1: return 8'(idx % (1 << dw));
            2'd2: begin
                v = 8'(SEED) & msk;
                for (int k = 0; k < idx; k++) v = v[0] ? ((v >> 1) ^ taps) : (v >> 1);
                return v;
            end
            default: return ((idx % 2) == 0) ? (8'h55 & msk) : (8'hAA & msk);
        endcase
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[%0d]: observed %0h expected %0h", tag, i, obs, exp);
        end
    endtask

    task automatic chk_reset();
        for (int i = 0; i < 2; i++) begin
            chk("rst_start", i, 32'(start[i]), 32'd0);
            chk("rst_we", i, 32'(we[i]), 32'd1);
            chk("rst_busy", i, 32'(busy[i]), 32'd0);
            chk("rst_done", i, 32'(done[i]), 32'd0);
            chk("rst_err", i, 32'(err[i]), 32'd0);
        end
    endtask

    // One run on instance i. drop_round>=0 lowers enable_i after the 2nd write of that round;
    // abort_acc>=0 returns early after that many accepts (no end checks).
    task automatic run(input int i, input logic [1:0] m, input int drop_round, input int abort_acc,
                       input int rdy_pct, input int bad_pct);
        int dw, rn, tot_rounds, tot_acc, a, cyc, r, p, nw, exp_err;
        logic [1:0] em;
        logic [7:0] v, msk;
        logic       go;
        dw  = dw_of(i);
        rn  = rounds_of(i);
        em  = (m == 2'd3) ? 2'd0 : m;
        msk = 8'((32'd1 << dw) - 32'd1);
        if (drop_round < 0) tot_rounds = (rn == 0) ? 1000000 : rn;
        else if (rn != 0 && rn < drop_round + 1) tot_rounds = rn;
        else tot_rounds = drop_round + 1;
        tot_acc = tot_rounds * 2 * BL;
        a = 0; cyc = 0; exp_err = 0;
        @(negedge clk);
        mode[i] = m; en[i] = 1'b1; rdy[i] = 1'b0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (cyc > 20000) begin
                errors++;
                $error("FAIL timeout[%0d]: observed %0d accepts expected %0d", i, a, tot_acc);
                rdy[i] = 1'b0; en[i] = 1'b0;
                return;
            end
            if (a == abort_acc) begin
                rdy[i] = 1'b0;
                return;
            end
            if (a == tot_acc) break;
            r  = a / (2 * BL);
            p  = a % (2 * BL);
            nw = r * BL + ((p < BL) ? p : BL);
            chk("start", i, 32'(start[i]), 32'd1);
            chk("busy", i, 32'(busy[i]), 32'd1);
            chk("done_run", i, 32'(done[i]), 32'd0);
            chk("we", i, 32'(we[i]), (p < BL) ? 32'd1 : 32'd0);
            chk("wr_dat", i, 32'(wr_dat[i]), 32'(pat(dw, em, nw)));
            mode[i] = 2'($urandom);
            go = ($urandom_range(99) < 32'(rdy_pct));
            rdy[i] = go;
            if (p >= BL) begin
                v = pat(dw, em, r * BL + p - BL);
`ifdef EMMC_TG_CHECK_EN
                if (go && ($urandom_range(99) < 32'(bad_pct))) begin
                    v = v ^ 8'($urandom_range(1, 32'(msk)));
                    exp_err++;
                end
`else
                if (bad_pct >= 0) v = 8'($urandom) & msk;
`endif
                rd_dat[i] = v;
            end else begin
                rd_dat[i] = 8'($urandom) & msk;
            end
            if (go) begin
                a++;
                if (drop_round >= 0 && a == drop_round * 2 * BL + 2) en[i] = 1'b0;
            end
        end
        rdy[i] = 1'b0;
        chk("end_start", i, 32'(start[i]), 32'd0);
        chk("end_busy", i, 32'(busy[i]), 32'd0);
        chk("end_done", i, 32'(done[i]), 32'd1);
        chk("end_err", i, 32'(err[i]), 32'(exp_err));
        en[i] = 1'b0;
        @(negedge clk);
        chk("idle_done", i, 32'(done[i]), 32'd0);
        chk("idle_start", i, 32'(start[i]), 32'd0);
        chk("idle_err", i, 32'(err[i]), 32'(exp_err));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk_reset();
        rst = 1'b0;

        run(0, 2'd0, -1, -1, 100, 0);   // ALT, ready always high, two rounds
        run(0, 2'd1, -1, -1, 50, 30);   // INC, ready toggling, corrupted reads
        run(0, 2'd2, -1, -1, 70, 20);   // LFSR
        run(0, 2'd3, -1, -1, 60, 10);   // reserved mode behaves as ALT
        run(0, 2'd1, 0, -1, 80, 0);     // enable drop in round 0 ends after one round
        run(1, 2'd1, 7, -1, 60, 15);    // INC on 4 bits wraps F->0
        run(1, 2'd2, 99, -1, 70, 5);    // LFSR, 100 rounds then enable drop mid-WR
        run(1, 2'd0, 2, -1, 100, 25);   // ALT on 4 bits

        run(1, 2'd2, -1, 14, 80, 50);   // abort in the read phase of round 1
        @(negedge clk);
        rst = 1'b1; en = '0; rdy = '0;
        #1;
        chk_reset();
        @(negedge clk);
        rst = 1'b0;
        run(1, 2'd2, 1, -1, 80, 10);    // replay from the LFSR seed

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
